// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide scheduler:
//   - md_op encodings (MD_MULT .. MD_MTLO)
//   - scheduler FSM states (ST_IDLE, ST_RUN)
//   - default latency / counter width constants
//   - small op-decode helpers
// ---------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W_DEF       = 4;

    // Long (multi-cycle) ops occupy codes 0..3: bit 1 selects divide,
    // bit 0 selects unsigned.
    function automatic logic md_is_long(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic md_is_div(input logic [2:0] op);
        return (op[2] == 1'b0) && op[1];
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// ---------------------------------------------------------------------------
// mdu_arith
// Combinational 32x32 multiply and 32/32 divide, signed or unsigned.
// Ports:
//   i_op       : md_op code (only MULT/MULTU/DIV/DIVU produce results)
//   i_a        : rs operand (multiplicand / dividend)
//   i_b        : rt operand (multiplier / divisor)
//   o_res_hi   : product[63:32] or remainder
//   o_res_lo   : product[31:0]  or quotient
//   o_div_zero : divide op with zero divisor
// ---------------------------------------------------------------------------
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_res_hi,
    output logic [31:0] o_res_lo,
    output logic        o_div_zero
);

    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_b_zero;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_prod_mag;
    logic [63:0] w_prod;

    // Everything is done on magnitudes and the sign is re-applied afterwards,
    // so 0x80000000 / -1 wraps to 0x80000000 without relying on signed-divide
    // overflow semantics.
    always_comb begin
        w_signed   = ~i_op[0];
        w_a_neg    = w_signed & i_a[31];
        w_b_neg    = w_signed & i_b[31];
        w_a_mag    = w_a_neg ? (32'd0 - i_a) : i_a;
        w_b_mag    = w_b_neg ? (32'd0 - i_b) : i_b;
        w_b_zero   = (i_b == '0);
        // Divisor forced to 1 on zero so the divider never produces X.
        w_divisor  = w_b_zero ? 32'd1 : w_b_mag;
        w_q_mag    = w_a_mag / w_divisor;
        w_r_mag    = w_a_mag % w_divisor;
        w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        w_prod_mag = {32'd0, w_a_mag} * {32'd0, w_b_mag};
        w_prod     = (w_a_neg ^ w_b_neg) ? (64'd0 - w_prod_mag) : w_prod_mag;
    end

    always_comb begin
        o_res_hi   = '0;
        o_res_lo   = '0;
        o_div_zero = 1'b0;
        if (md_is_long(i_op)) begin
            if (md_is_div(i_op)) begin
                o_res_hi   = w_rem;
                o_res_lo   = w_quot;
                o_div_zero = w_b_zero;
            end else begin
                o_res_hi   = w_prod[63:32];
                o_res_lo   = w_prod[31:0];
            end
        end
    end

endmodule

// File: rtl/mdu_sched.sv
// ---------------------------------------------------------------------------
// mdu_sched
// Sequencing controller for the MIPS multiply/divide unit. Owns HI/LO,
// models fixed MULT/DIV latency with a down-counter, and raises a stall
// request when a D-stage HI/LO user must wait.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   start, md_op      : E-stage op pulse and op code (mdu_pkg::md_op_e)
//   rs_val, rt_val    : forwarded operands
//   d_uses_md         : D-stage instruction uses the MDU or HI/LO
//   mf_sel            : 0 = read LO, 1 = read HI on mf_data
//   busy              : long op in progress
//   stall_md          : stall request to hazard unit (combinational)
//   hi, lo            : architectural HI/LO
//   mf_data           : selected HI/LO (combinational)
//   cancel            : only when MDU_CANCEL_EN is defined; aborts the
//                       running op or suppresses a coincident start
// ---------------------------------------------------------------------------
module mdu_sched
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_md,
    input  logic        mf_sel,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
`ifdef MDU_CANCEL_EN
    ,
    input  logic        cancel
`endif
);

    mdu_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic             r_pend_dz;

    logic             w_cancel;
    logic             w_start_eff;
    logic             w_long;
    logic [CNT_W-1:0] w_load;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    assign w_long      = md_is_long(md_op);
    assign w_start_eff = start & ~w_cancel;
    assign w_load      = md_is_div(md_op) ? CNT_W'(DIV_CYCLES - 1)
                                          : CNT_W'(MULT_CYCLES - 1);

    mdu_arith u_arith (
        .i_op       (md_op),
        .i_a        (rs_val),
        .i_b        (rt_val),
        .o_res_hi   (w_res_hi),
        .o_res_lo   (w_res_lo),
        .o_div_zero (w_div_zero)
    );

    // Result is computed at issue and parked in pend_*; the counter only
    // models latency. A start seen in RUN falls through untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_dz <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_eff) begin
                        if (w_long) begin
                            r_pend_hi <= w_res_hi;
                            r_pend_lo <= w_res_lo;
                            r_pend_dz <= w_div_zero;
                            r_cnt     <= w_load;
                            r_busy    <= 1'b1;
                            r_state   <= ST_RUN;
                        end else if (md_op == MD_MTHI) begin
                            r_hi <= rs_val;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= rs_val;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_cancel) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        if (!r_pend_dz) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign mf_data  = mf_sel ? r_hi : r_lo;
    assign stall_md = d_uses_md & (r_busy | (start & w_long));

`ifndef SYNTHESIS
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!reset_n) !(start && r_busy)
    );
`endif

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_md;
    logic        mf_sel;
    logic        cancel;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference architectural state
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mdu_sched #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .d_uses_md (d_uses_md),
        .mf_sel    (mf_sel),
        .busy      (busy),
        .stall_md  (stall_md),
        .hi        (hi),
        .lo        (lo),
        .mf_data   (mf_data)
`ifdef MDU_CANCEL_EN
        ,
        .cancel    (cancel)
`endif
    );

    // Behavioural reference: MIPS semantics in 64-bit arithmetic.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        n  = 0;
        case (op)
            3'd0: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; n = 5; end
            3'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; n = 5; end
            3'd2: begin
                if (b != 0) begin
                    sp = sa / sb; m_lo = sp[31:0];
                    sp = sa % sb; m_hi = sp[31:0];
                end
                n = 10;
            end
            3'd3: begin
                if (b != 0) begin
                    up = ua / ub; m_lo = up[31:0];
                    up = ua % ub; m_hi = up[31:0];
                end
                n = 10;
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    // Issue one op at a negedge; return busy-cycle count (bounded) and the
    // stall_md value seen in the start cycle. Returns in the first non-busy
    // cycle, so a following issue is back-to-back.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int nbusy,
                         output logic st0);
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        #1 st0 = stall_md;
        @(posedge clk);
        #1 start = 1'b0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 40) begin
            nbusy++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_reset();
        start = 0; md_op = 0; rs_val = 0; rt_val = 0;
        d_uses_md = 0; mf_sel = 0; cancel = 0;
        do_reset();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
        n_cmp++; if (stall_md !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", stall_md); end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [3] = '{3'd0, 3'd3, 3'd2};
        logic [31:0] as  [3] = '{32'hFFFFFFFE, 32'd100, 32'hFFFFFFF9};
        logic [31:0] bs  [3] = '{32'd3, 32'd7, 32'd2};
        logic [31:0] eh  [3] = '{32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF};
        logic [31:0] el  [3] = '{32'hFFFFFFFA, 32'd14, 32'hFFFFFFFD};
        int          en  [3] = '{5, 10, 10};
        int nb;
        logic st;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], nb, st);
            n_cmp++; if (nb != en[i]) begin n_fail++; $display("FAIL dir%0d_busy got=%0d exp=%0d", i, nb, en[i]); end
            n_cmp++; if (hi !== eh[i]) begin n_fail++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, eh[i]); end
            n_cmp++; if (lo !== el[i]) begin n_fail++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, el[i]); end
            mf_sel = 1'b1; #1;
            n_cmp++; if (mf_data !== eh[i]) begin n_fail++; $display("FAIL dir%0d_mfhi got=%h exp=%h", i, mf_data, eh[i]); end
            mf_sel = 1'b0; #1;
            n_cmp++; if (mf_data !== el[i]) begin n_fail++; $display("FAIL dir%0d_mflo got=%h exp=%h", i, mf_data, el[i]); end
        end
        m_hi = hi_exp_last(eh[2]);
        m_lo = el[2];
    endtask

    function automatic logic [31:0] hi_exp_last(input logic [31:0] v);
        return v;
    endfunction

    task automatic test_div_zero();
        int nb;
        logic st;
        issue(3'd4, 32'h11, 32'd0, nb, st);
        n_cmp++; if (nb != 0) begin n_fail++; $display("FAIL mthi_busy got=%0d exp=0", nb); end
        issue(3'd5, 32'h22, 32'd0, nb, st);
        n_cmp++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("FAIL mtx_preload got=%h/%h exp=11/22", hi, lo); end
        issue(3'd2, 32'd1234, 32'd0, nb, st);
        n_cmp++; if (nb != 10) begin n_fail++; $display("FAIL divz_busy got=%0d exp=10", nb); end
        n_cmp++; if (hi !== 32'h11 || lo !== 32'h22) begin n_fail++; $display("FAIL divz_hilo got=%h/%h exp=11/22", hi, lo); end
        m_hi = 32'h11;
        m_lo = 32'h22;
    endtask

    task automatic test_stall();
        int cyc;
        // d_uses_md held high across a MULT
        @(negedge clk);
        d_uses_md = 1'b1; start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd5;
        #1;
        n_cmp++; if (stall_md !== 1'b1) begin n_fail++; $display("FAIL stall_start got=%0b exp=1", stall_md); end
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (stall_md !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy%0d got=%0b/%0b exp=1/1", i, stall_md, busy); end
            @(posedge clk); #1;
        end
        n_cmp++; if (stall_md !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall_after got=%0b/%0b exp=0/0", stall_md, busy); end
        n_cmp++; if (lo !== 32'd15) begin n_fail++; $display("FAIL stall_lo got=%h exp=f", lo); end
        m_hi = 32'd0; m_lo = 32'd15;
        // d_uses_md low: stall never raised
        d_uses_md = 1'b0;
        @(negedge clk);
        start = 1'b1; md_op = 3'd0;
        #1;
        cyc = 0;
        n_cmp++; if (stall_md !== 1'b0) begin n_fail++; $display("FAIL nostall_start got=%0b exp=0", stall_md); end
        @(posedge clk); #1 start = 1'b0;
        while (busy === 1'b1 && cyc < 40) begin
            if (stall_md !== 1'b0) cyc = 100;
            else cyc++;
            @(posedge clk); #1;
        end
        n_cmp++; if (cyc != 5) begin n_fail++; $display("FAIL nostall_busy got=%0d exp=5", cyc); end
    endtask

    task automatic test_mid_reset();
        int nb;
        logic st;
        issue(3'd4, 32'hAA, 32'd0, nb, st);
        issue(3'd5, 32'hBB, 32'd0, nb, st);
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; rs_val = 32'd50; rt_val = 32'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mrst_busy got=%0b exp=0", busy); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL mrst_hilo got=%h/%h exp=0/0", hi, lo); end
        @(negedge clk); reset_n = 1'b1;
        issue(3'd1, 32'd6, 32'd7, nb, st);
        n_cmp++; if (nb != 5) begin n_fail++; $display("FAIL mrst_multu_busy got=%0d exp=5", nb); end
        n_cmp++; if (lo !== 32'd42 || hi !== 32'd0) begin n_fail++; $display("FAIL mrst_multu got=%h/%h exp=0/2a", hi, lo); end
        m_hi = 32'd0; m_lo = 32'd42;
    endtask

    function automatic logic [31:0] pick_val();
        int unsigned sel = $urandom_range(0, 7);
        case (sel)
            0: return 32'h80000000;
            1: return 32'hFFFFFFFF;
            2: return 32'd1;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int nb, ne;
        logic st;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = pick_val();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_val();
            ref_op(op, a, b, ne);
            issue(op, a, b, nb, st);
            n_cmp++; if (nb != ne) begin n_fail++; $display("FAIL rnd%0d_busy op=%0d got=%0d exp=%0d", i, op, nb, ne); end
            n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
                n_fail++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got=%h/%h exp=%h/%h", i, op, a, b, hi, lo, m_hi, m_lo);
            end
            mf_sel = 1'($urandom_range(0, 1)); #1;
            n_cmp++; if (mf_data !== (mf_sel ? m_hi : m_lo)) begin n_fail++; $display("FAIL rnd%0d_mf got=%h", i, mf_data); end
        end
    endtask

`ifdef MDU_CANCEL_EN
    task automatic test_cancel();
        int nb;
        logic st;
        issue(3'd5, 32'd5, 32'd0, nb, st);
        @(negedge clk);
        start = 1'b1; md_op = 3'd0; rs_val = 32'd4; rt_val = 32'd4;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);   // busy cycle 1
        @(negedge clk);   // busy cycle 2
        cancel = 1'b1;
        @(posedge clk); #1 cancel = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got=%0b exp=0", busy); end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (lo !== 32'd5) begin n_fail++; $display("FAIL cancel_lo got=%h exp=5", lo); end
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; md_op = 3'd5; rs_val = 32'd9;
        @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
        n_cmp++; if (lo !== 32'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL cancel_mtlo got=%h/%0b exp=5/0", lo, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_stall();
        test_mid_reset();
        test_random();
`ifdef MDU_CANCEL_EN
        test_cancel();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
